// File: rtl/exec_stage_if.sv
// Instruction handshake, register-stack read/write port and status flags of the execute stage.
// slave is the execute stage's view; master is the instruction source / register stack side.
interface exec_stage_if #(
  parameter int WORD_SIZE = 16,
  parameter int NIB_SIZE  = 4
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [2:0]           op;
  logic [NIB_SIZE-1:0]  dst;
  logic [NIB_SIZE-1:0]  src1;
  logic [NIB_SIZE-1:0]  src2;
  logic [WORD_SIZE-1:0] imm;
  logic [NIB_SIZE-1:0]  num1;
  logic [NIB_SIZE-1:0]  num2;
  logic                 get_clk;
  logic [WORD_SIZE-1:0] out1;
  logic [WORD_SIZE-1:0] out2;
  logic [NIB_SIZE-1:0]  setnum;
  logic [WORD_SIZE-1:0] setval;
  logic                 set_clk;
  logic                 done;
  logic                 zero_flag;
  logic                 carry_flag;

  modport slave (
    input  instr_valid, op, dst, src1, src2, imm, out1, out2,
    output instr_ready, num1, num2, get_clk, setnum, setval, set_clk, done, zero_flag, carry_flag
  );

  modport master (
    output instr_valid, op, dst, src1, src2, imm, out1, out2,
    input  instr_ready, num1, num2, get_clk, setnum, setval, set_clk, done, zero_flag, carry_flag
  );
endinterface

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: register read, ALU or shift-add multiply, strobed write-back; all outputs registered.
// Latency 4 cycles (MUL 4+WORD_SIZE, NOP 2); instr_ready only in IDLE, so the source stalls while busy.
module exec_stage #(
  parameter int WORD_SIZE = 16,
  parameter int NIB_SIZE  = 4
) (
  input logic         clk,
  input logic         reset,
  exec_stage_if.slave bus
);
  localparam int            CW       = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WORD_SIZE - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, EXEC, MULT, WSETUP, WSTROBE} state_e;
  state_e state_q, state_d;

  logic [2:0]             op_q, op_d;
  logic [NIB_SIZE-1:0]    dst_q, dst_d;
  logic [NIB_SIZE-1:0]    num1_q, num1_d;
  logic [NIB_SIZE-1:0]    num2_q, num2_d;
  logic [NIB_SIZE-1:0]    setnum_q, setnum_d;
  logic [WORD_SIZE-1:0]   imm_q, imm_d;
  logic [WORD_SIZE-1:0]   a_q, a_d;
  logic [WORD_SIZE-1:0]   b_q, b_d;
  logic [WORD_SIZE-1:0]   setval_q, setval_d;
  logic [2*WORD_SIZE-1:0] prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   get_clk_q, get_clk_d;
  logic                   set_clk_q, set_clk_d;
  logic                   done_q, done_d;
  logic                   zero_q, zero_d;
  logic                   carry_q, carry_d;

  logic                   accept;
  logic [WORD_SIZE:0]     sum, diff, mul_add;
  logic [WORD_SIZE-1:0]   res;
  logic                   res_c;

  assign accept = bus.instr_valid && ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // MUL leaves MULT through EXEC so the product is committed on the same path as the ALU ops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = (op_q == OP_MUL) ? MULT : EXEC;
      MULT:    if (cnt_q == MUL_LAST) state_d = EXEC;
      EXEC:    state_d = (op_q == OP_NOP) ? IDLE : WSETUP;
      WSETUP:  state_d = WSTROBE;
      WSTROBE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    res   = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD:  begin res = sum[WORD_SIZE-1:0];  res_c = sum[WORD_SIZE];  end
      OP_SUB:  begin res = diff[WORD_SIZE-1:0]; res_c = diff[WORD_SIZE]; end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_LDI:  res = imm_q;
      OP_MUL:  begin res = prod_q[WORD_SIZE-1:0]; res_c = |prod_q[2*WORD_SIZE-1:WORD_SIZE]; end
      default: ;
    endcase
  end

  // Shift-add: high half accumulates A when the multiplier LSB (low half) is set, then the pair shifts right.
  assign mul_add = {1'b0, prod_q[2*WORD_SIZE-1:WORD_SIZE]} + {1'b0, (prod_q[0] ? a_q : '0)};

  always_comb begin
    op_d      = op_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    setnum_d  = setnum_q;
    setval_d  = setval_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ready_d   = (state_d == IDLE);
    get_clk_d = (state_d == READ);
    set_clk_d = (state_d == WSTROBE);
    done_d    = (state_q != IDLE) && (state_d == IDLE);
    case (state_q)
      IDLE: if (accept) begin
        op_d   = bus.op;
        dst_d  = bus.dst;
        imm_d  = bus.imm;
        num1_d = bus.src1;
        num2_d = bus.src2;
      end
      READ: begin
        a_d    = bus.out1;
        b_d    = bus.out2;
        prod_d = {{WORD_SIZE{1'b0}}, bus.out2};
        cnt_d  = '0;
      end
      MULT: begin
        prod_d = {mul_add, prod_q[WORD_SIZE-1:1]};
        cnt_d  = cnt_q + CW'(1);
      end
      EXEC: if (op_q != OP_NOP) begin
        setnum_d = dst_q;
        setval_d = res;
        zero_d   = (res == '0);
        carry_d  = res_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      setnum_q  <= '0;
      setval_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b0;
      get_clk_q <= 1'b0;
      set_clk_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      a_q       <= a_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      setnum_q  <= setnum_d;
      setval_q  <= setval_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ready_q   <= ready_d;
      get_clk_q <= get_clk_d;
      set_clk_q <= set_clk_d;
      done_q    <= done_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.num1        = num1_q;
  assign bus.num2        = num2_q;
  assign bus.get_clk     = get_clk_q;
  assign bus.setnum      = setnum_q;
  assign bus.setval      = setval_q;
  assign bus.set_clk     = set_clk_q;
  assign bus.done        = done_q;
  assign bus.zero_flag   = zero_q;
  assign bus.carry_flag  = carry_q;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: architectural register-file model feeds a scoreboard queue; a monitor checks
// each write strobe and done pulse against it. Includes a small register stack attached to the DUT.
module tb_exec_stage;
  localparam int W = 16;
  localparam int N = 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDI = 3'd5, MUL = 3'd6, NOP = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_stage_if #(.WORD_SIZE(W), .NIB_SIZE(N)) bus ();
  exec_stage #(.WORD_SIZE(W), .NIB_SIZE(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Register stack: combinational read, write on set_clk rising edge.
  logic [W-1:0] stk [16] = '{default: '0};
  assign bus.out1 = stk[bus.num1];
  assign bus.out2 = stk[bus.num2];
  always @(posedge bus.set_clk) stk[bus.setnum] <= bus.setval;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  dst;
    logic [15:0] val;
    bit          z;
    bit          c;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] mregs [16] = '{default: '0};
  bit mz = 1'b0, mc = 1'b0;

  // Architectural model: one instruction at a time against the model register file.
  task automatic model(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] imm, output exp_t e);
    int unsigned a, b, r, p;
    bit c;
    a = mregs[s1];
    b = mregs[s2];
    r = 0;
    c = 1'b0;
    e.wr = 1'b1;
    e.dst = d;
    e.lat = 4;
    e.acc = 0;
    case (op)
      ADD:  begin r = a + b; c = (r > 32'hFFFF); end
      SUB:  begin r = (a - b) & 32'hFFFF; c = (a < b); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      LDI:  r = imm;
      MUL:  begin p = a * b; r = p & 32'hFFFF; c = ((p >> 16) != 0); e.lat = 4 + W; end
      default: begin e.wr = 1'b0; e.lat = 2; end
    endcase
    e.val = r[15:0];
    if (e.wr) begin
      mz = (r[15:0] == 16'h0);
      mc = c;
      mregs[d] = r[15:0];
    end
    e.z = mz;
    e.c = mc;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] imm, input bit hold, output int acc);
    exp_t e;
    int n;
    bus.op = op; bus.dst = d; bus.src1 = s1; bus.src2 = s2; bus.imm = imm;
    bus.instr_valid = 1'b1;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.instr_ready), 32'd1);
    if (bus.instr_ready !== 1'b1) begin
      bus.instr_valid = 1'b0;
      acc = -1;
      return;
    end
    model(op, d, s1, s2, imm, e);
    acc = cyc + 1;
    e.acc = acc;
    exp_q.push_back(e);
    @(negedge clk);
    // Junk on the inputs while busy must be ignored.
    bus.op = 3'($urandom); bus.dst = 4'($urandom); bus.src1 = 4'($urandom);
    bus.src2 = 4'($urandom); bus.imm = 16'($urandom);
    bus.instr_valid = hold ? 1'b1 : 1'($urandom);
    @(negedge clk);
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bus.instr_ready), 0);
    chk({tag, "_getclk"}, 32'(bus.get_clk), 0);
    chk({tag, "_setclk"}, 32'(bus.set_clk), 0);
    chk({tag, "_done"},   32'(bus.done), 0);
    chk({tag, "_num1"},   32'(bus.num1), 0);
    chk({tag, "_num2"},   32'(bus.num2), 0);
    chk({tag, "_setnum"}, 32'(bus.setnum), 0);
    chk({tag, "_setval"}, 32'(bus.setval), 0);
    chk({tag, "_zero"},   32'(bus.zero_flag), 0);
    chk({tag, "_carry"},  32'(bus.carry_flag), 0);
  endtask

  // Monitor
  int wr_cnt = 0;
  int last_done = -1;
  bit prev_set = 1'b0, prev_done = 1'b0, seen_wr = 1'b0;
  logic [3:0] pnum = '0;
  logic [15:0] pval = '0;
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      prev_set = 1'b0; prev_done = 1'b0; seen_wr = 1'b0;
    end else begin
      if (bus.set_clk) begin
        chk("set_clk_single", 32'(prev_set), 0);
        if (!prev_set) begin
          wr_cnt++;
          seen_wr = 1'b1;
          chk("setnum_stable", 32'(bus.setnum), 32'(pnum));
          chk("setval_stable", 32'(bus.setval), 32'(pval));
          chk("write_pending", 32'(exp_q.size()), 1);
          if (exp_q.size() != 0) begin
            chk("write_allowed", 32'(bus.set_clk), 32'(exp_q[0].wr));
            chk("setnum", 32'(bus.setnum), 32'(exp_q[0].dst));
            chk("setval", 32'(bus.setval), 32'(exp_q[0].val));
          end
        end
      end
      pnum = bus.setnum;
      pval = bus.setval;
      prev_set = bus.set_clk;
      if (bus.done) begin
        chk("done_single", 32'(prev_done), 0);
        chk("done_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          chk("latency", 32'(cyc - me.acc), 32'(me.lat));
          chk("zero_flag", 32'(bus.zero_flag), 32'(me.z));
          chk("carry_flag", 32'(bus.carry_flag), 32'(me.c));
          chk("wrote", 32'(seen_wr), 32'(me.wr));
          chk("ready_in_done", 32'(bus.instr_ready), 1);
        end
        seen_wr = 1'b0;
        last_done = cyc;
      end
      prev_done = bus.done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_n, wr_snap, n;
    logic [15:0] saved [16];
    bus.instr_valid = 1'b0;
    bus.op = '0; bus.dst = '0; bus.src1 = '0; bus.src2 = '0; bus.imm = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.instr_ready), 1);

    // ADD 5+7
    issue(LDI, 1, 0, 0, 16'd5, 0, acc);
    issue(LDI, 2, 0, 0, 16'd7, 0, acc);
    issue(ADD, 3, 1, 2, 16'd0, 0, acc);
    // SUB wrap and SUB zero
    issue(LDI, 1, 0, 0, 16'd3, 0, acc);
    issue(LDI, 2, 0, 0, 16'd5, 0, acc);
    issue(SUB, 4, 1, 2, 16'd0, 0, acc);
    issue(LDI, 1, 0, 0, 16'd9, 0, acc);
    issue(LDI, 2, 0, 0, 16'd9, 0, acc);
    issue(SUB, 5, 1, 2, 16'd0, 0, acc);
    // MUL overflow and MUL 300*200
    issue(LDI, 1, 0, 0, 16'h0100, 0, acc);
    issue(LDI, 2, 0, 0, 16'h0200, 0, acc);
    issue(MUL, 1, 1, 2, 16'd0, 0, acc);
    issue(LDI, 1, 0, 0, 16'd300, 0, acc);
    issue(LDI, 2, 0, 0, 16'd200, 0, acc);
    issue(MUL, 7, 1, 2, 16'd0, 0, acc);
    // Aliasing with valid held high; next instruction taken in the done cycle
    issue(LDI, 2, 0, 0, 16'h00FF, 1, acc);
    issue(XOR_, 2, 2, 2, 16'd0, 1, acc);
    issue(ADD, 8, 1, 2, 16'd0, 0, acc_n);
    chk("accept_in_done_cycle", 32'(acc_n), 32'(last_done + 1));
    // NOP
    issue(NOP, 9, 1, 2, 16'd0, 0, acc);
    wait_idle();
    chk("r2_after_xor", 32'(stk[2]), 32'(mregs[2]));

    // Reset in the middle of MUL
    issue(LDI, 1, 0, 0, 16'd1234, 0, acc);
    issue(LDI, 2, 0, 0, 16'd77, 0, acc);
    wait_idle();
    saved = mregs;
    wr_snap = wr_cnt;
    issue(MUL, 9, 1, 2, 16'd0, 0, acc);
    n = 0;
    while (cyc != acc + 10 && n < 100) begin @(negedge clk); n++; end
    #1 reset = 1'b1;
    #1 chk_reset_outputs("mulrst");
    exp_q.delete();
    mregs = saved; mz = 1'b0; mc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_mulrst", 32'(bus.instr_ready), 1);
    chk("mulrst_no_write", 32'(wr_cnt), 32'(wr_snap));
    chk("mulrst_r9", 32'(stk[9]), 32'(mregs[9]));
    issue(LDI, 6, 0, 0, 16'h1234, 0, acc);
    wait_idle();
    chk("r6_ldi", 32'(stk[6]), 32'(mregs[6]));

    // Reset while in WSETUP
    saved = mregs;
    wr_snap = wr_cnt;
    issue(ADD, 10, 1, 2, 16'd0, 0, acc);
    n = 0;
    while (cyc != acc + 2 && n < 100) begin @(negedge clk); n++; end
    #1 reset = 1'b1;
    #1 chk("wsetup_rst_setclk", 32'(bus.set_clk), 0);
    exp_q.delete();
    mregs = saved; mz = 1'b0; mc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("wsetup_no_write", 32'(wr_cnt), 32'(wr_snap));
    chk("wsetup_r10", 32'(stk[10]), 32'(mregs[10]));

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
            16'($urandom), (i < 39) ? 1'($urandom) : 1'b0, acc);
    end
    wait_idle();
    for (int r = 0; r < 16; r++) chk("final_reg", 32'(stk[r]), 32'(mregs[r]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
